// File: rtl/mips_mem_responder.sv
// Memory-mapped responder for the multicycle MIPS memory port: word RAM,
// two switch input ports and one output port, all with one-cycle read latency.
module mips_mem_responder #(
  parameter int          ADDR_WIDTH   = 8,
  parameter logic [31:0] INPORT0_ADDR = 32'h0000FFF8,
  parameter logic [31:0] INPORT1_ADDR = 32'h0000FFFC,
  parameter logic [31:0] OUTPORT_ADDR = 32'h0000FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic [9:0]  in_switch,
  input  logic        inport0_en,
  input  logic        inport1_en,
  output logic [31:0] outport,
  output logic        out_strobe,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [1:0] {IDLE, RD_RESP, WR_ACK} state_t;

  state_t state_reg, state_next;

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  logic [31:0] rd_data_reg;
  logic [31:0] outport_reg;
  logic        out_hit_reg;
  logic        err_reg;
  logic [9:0]  inport0_reg;
  logic [9:0]  inport1_reg;

  logic [31:0]           aligned_addr;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_hit, in0_hit, in1_hit, out_hit;
  logic                  rd_req, err_set;
  logic [31:0]           rd_data_next;

  // RAM takes priority over the ports if parameters ever make them overlap.
  assign aligned_addr = {addr[31:2], 2'b00};
  assign ram_idx      = addr[ADDR_WIDTH+1:2];
  assign ram_hit      = ((addr >> (ADDR_WIDTH + 2)) == 32'd0);
  assign in0_hit      = !ram_hit && (aligned_addr == INPORT0_ADDR);
  assign in1_hit      = !ram_hit && (aligned_addr == INPORT1_ADDR);
  assign out_hit      = !ram_hit && (aligned_addr == OUTPORT_ADDR);
  assign rd_req       = MemRead && !MemWrite;

  assign err_set = (MemRead && MemWrite)
                || ((MemRead || MemWrite) && (addr[1:0] != 2'b00))
                || (rd_req && !ram_hit && !in0_hit && !in1_hit)
                || (MemWrite && !ram_hit && !out_hit);

  always_comb begin
    rd_data_next = 32'd0;
    if (ram_hit)      rd_data_next = mem[ram_idx];
    else if (in0_hit) rd_data_next = {22'd0, inport0_reg};
    else if (in1_hit) rd_data_next = {22'd0, inport1_reg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (MemWrite)     state_next = WR_ACK;
    else if (MemRead) state_next = RD_RESP;
  end

  always_comb begin
    rd_valid   = (state_reg == RD_RESP);
    out_strobe = (state_reg == WR_ACK) && out_hit_reg;
  end

  // RAM array carries no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) mem[ram_idx] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg <= 32'd0;
      outport_reg <= 32'd0;
      out_hit_reg <= 1'b0;
      err_reg     <= 1'b0;
      inport0_reg <= 10'd0;
      inport1_reg <= 10'd0;
    end else begin
      if (rd_req) rd_data_reg <= rd_data_next;
      out_hit_reg <= MemWrite && out_hit;
      if (MemWrite && out_hit) outport_reg <= wr_data;
      if (err_set)      err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;
      if (inport0_en) inport0_reg <= in_switch;
      if (inport1_en) inport1_reg <= in_switch;
    end
  end

  assign rd_data = rd_data_reg;
  assign outport = outport_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Self-checking bench for mips_mem_responder: directed vector table, async
// reset sequence and randomized traffic against a behavioural model.
module tb_mips_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] addr = 32'd0, wr_data = 32'd0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [9:0]  in_switch = 10'd0;
  logic        inport0_en = 1'b0, inport1_en = 1'b0;
  logic [31:0] outport;
  logic        out_strobe;
  logic        err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  mips_mem_responder dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid),
    .in_switch(in_switch), .inport0_en(inport0_en), .inport1_en(inport1_en),
    .outport(outport), .out_strobe(out_strobe), .err(err), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state
  logic [31:0] m_mem [0:255];
  logic [9:0]  m_in0, m_in1;
  logic [31:0] m_data, m_out;
  logic        m_valid, m_strobe, m_err;

  typedef struct {
    logic        rd, wr;
    logic [31:0] a, wd;
    logic [9:0]  sw;
    logic        en0, en1, clr;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_err;
    logic [31:0] e_out;
    logic        e_strobe;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_in0 = 0; m_in1 = 0; m_data = 0; m_out = 0;
    m_valid = 0; m_strobe = 0; m_err = 0;
  endtask

  // Applies the documented rules to the inputs sampled at the last edge.
  task automatic model_step();
    logic [31:0] al;
    logic is_ram, bad;
    al     = {addr[31:2], 2'b00};
    is_ram = addr < 32'd1024;
    bad    = 1'b0;
    m_valid  = 1'b0;
    m_strobe = 1'b0;
    if ((MemRead || MemWrite) && addr[1:0] != 2'b00) bad = 1'b1;
    if (MemRead && MemWrite) bad = 1'b1;
    if (MemWrite) begin
      if (is_ram) m_mem[addr[9:2]] = wr_data;
      else if (al == 32'h0000FFFC) begin m_out = wr_data; m_strobe = 1'b1; end
      else bad = 1'b1;
    end else if (MemRead) begin
      m_valid = 1'b1;
      if (is_ram)                  m_data = m_mem[addr[9:2]];
      else if (al == 32'h0000FFF8) m_data = {22'd0, m_in0};
      else if (al == 32'h0000FFFC) m_data = {22'd0, m_in1};
      else begin m_data = 32'd0; bad = 1'b1; end
    end
    if (bad) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    if (inport0_en) m_in0 = in_switch;
    if (inport1_en) m_in1 = in_switch;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rd_valid"},   {31'd0, rd_valid},   {31'd0, m_valid});
    check({tag, ".rd_data"},    rd_data,             m_data);
    check({tag, ".outport"},    outport,             m_out);
    check({tag, ".out_strobe"}, {31'd0, out_strobe}, {31'd0, m_strobe});
    check({tag, ".err"},        {31'd0, err},        {31'd0, m_err});
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [9:0] sw,
                       input logic en0, input logic en1, input logic clr);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; addr = a; wr_data = wd;
    in_switch = sw; inport0_en = en0; inport1_en = en1; err_clr = clr;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    drive(0, 0, 32'd0, 32'd0, in_switch, 0, 0, 0);
  endtask

  task automatic addv(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [9:0] sw, input logic en0,
                      input logic en1, input logic clr, input logic ev,
                      input logic [31:0] ed, input logic ee, input logic [31:0] eo,
                      input logic es);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd; v.sw = sw; v.en0 = en0; v.en1 = en1;
    v.clr = clr; v.e_valid = ev; v.e_data = ed; v.e_err = ee; v.e_out = eo; v.e_strobe = es;
    tbl.push_back(v);
  endtask

  initial begin
    model_reset();
    // Power-up reset
    #12;
    check("reset.rd_valid", {31'd0, rd_valid}, 32'd0);
    check("reset.rd_data", rd_data, 32'd0);
    check("reset.err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Initialise every RAM word so the model knows all contents
    for (int i = 0; i < 256; i++) drive(0, 1, i * 4, $urandom, 10'd0, 0, 0, 0);
    idle();
    check_model("init");

    // Directed table, starting with outport=0
    addv(0,1,32'h10,  32'hDEADBEEF,10'h000,0,0,0, 0,32'h0,       0,32'h0,     0);
    addv(0,1,32'h14,  32'h12345678,10'h000,0,0,0, 0,32'h0,       0,32'h0,     0);
    addv(1,0,32'h10,  32'h0,       10'h000,0,0,0, 1,32'hDEADBEEF,0,32'h0,     0);
    addv(1,0,32'h14,  32'h0,       10'h000,0,0,0, 1,32'h12345678,0,32'h0,     0);
    addv(0,0,32'h0,   32'h0,       10'h2A5,1,0,0, 0,32'h0,       0,32'h0,     0);
    addv(0,0,32'h0,   32'h0,       10'h0F3,0,1,0, 0,32'h0,       0,32'h0,     0);
    addv(0,0,32'h0,   32'h0,       10'h3FF,0,0,0, 0,32'h0,       0,32'h0,     0);
    addv(1,0,32'hFFF8,32'h0,       10'h3FF,0,0,0, 1,32'h2A5,     0,32'h0,     0);
    addv(1,0,32'hFFFC,32'h0,       10'h3FF,0,0,0, 1,32'h0F3,     0,32'h0,     0);
    addv(0,1,32'hFFFC,32'h0000ABCD,10'h3FF,0,0,0, 0,32'h0,       0,32'hABCD,  1);
    addv(0,0,32'h0,   32'h0,       10'h3FF,0,0,0, 0,32'h0,       0,32'hABCD,  0);
    addv(1,0,32'hFFFC,32'h0,       10'h3FF,0,0,0, 1,32'h0F3,     0,32'hABCD,  0);
    addv(1,0,32'h4000,32'h0,       10'h3FF,0,0,0, 1,32'h0,       1,32'hABCD,  0);
    addv(0,0,32'h0,   32'h0,       10'h3FF,0,0,1, 0,32'h0,       0,32'hABCD,  0);
    addv(0,1,32'hFFF8,32'h1,       10'h3FF,0,0,0, 0,32'h0,       1,32'hABCD,  0);
    addv(0,0,32'h0,   32'h0,       10'h3FF,0,0,1, 0,32'h0,       0,32'hABCD,  0);
    addv(1,0,32'hFFF8,32'h0,       10'h3FF,0,0,0, 1,32'h2A5,     0,32'hABCD,  0);
    addv(1,0,32'h11,  32'h0,       10'h3FF,0,0,0, 1,32'hDEADBEEF,1,32'hABCD,  0);
    addv(0,0,32'h0,   32'h0,       10'h3FF,0,0,1, 0,32'h0,       0,32'hABCD,  0);
    addv(1,1,32'h20,  32'h55AA55AA,10'h3FF,0,0,0, 0,32'h0,       1,32'hABCD,  0);
    addv(0,0,32'h0,   32'h0,       10'h3FF,0,0,1, 0,32'h0,       0,32'hABCD,  0);
    addv(1,0,32'h20,  32'h0,       10'h3FF,0,0,0, 1,32'h55AA55AA,0,32'hABCD,  0);
    addv(1,0,32'hFFF8,32'h0,       10'h111,1,0,0, 1,32'h2A5,     0,32'hABCD,  0);
    addv(1,0,32'hFFF8,32'h0,       10'h111,0,0,0, 1,32'h111,     0,32'hABCD,  0);
    addv(0,1,32'h30,  32'hCAFEF00D,10'h111,0,0,0, 0,32'h0,       0,32'hABCD,  0);
    addv(1,0,32'h30,  32'h0,       10'h111,0,0,0, 1,32'hCAFEF00D,0,32'hABCD,  0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].sw,
            tbl[i].en0, tbl[i].en1, tbl[i].clr);
      $display("vec %0d rd=%0b wr=%0b addr=%08h -> valid=%0b data=%08h err=%0b out=%08h strobe=%0b",
               i, tbl[i].rd, tbl[i].wr, tbl[i].a, rd_valid, rd_data, err, outport, out_strobe);
      check($sformatf("vec%0d.rd_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) check($sformatf("vec%0d.rd_data", i), rd_data, tbl[i].e_data);
      check($sformatf("vec%0d.err", i), {31'd0, err}, {31'd0, tbl[i].e_err});
      check($sformatf("vec%0d.outport", i), outport, tbl[i].e_out);
      check($sformatf("vec%0d.out_strobe", i), {31'd0, out_strobe}, {31'd0, tbl[i].e_strobe});
      check_model($sformatf("vec%0d", i));
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic rd, wr;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5)       a = {22'd0, 8'($urandom), 2'b00};
      else if (sel == 5) a = 32'($urandom_range(0, 1023));
      else if (sel == 6) a = 32'hFFF8;
      else if (sel == 7) a = 32'hFFFC;
      else if (sel == 8) a = 32'hFFF8 | 32'($urandom_range(0, 3));
      else               a = 32'h400 + 32'($urandom_range(0, 32'h3FFF));
      rd = ($urandom_range(0, 2) != 0);
      wr = ($urandom_range(0, 2) == 0);
      drive(rd, wr, a, $urandom, 10'($urandom), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      $display("rnd %0d rd=%0b wr=%0b addr=%08h -> valid=%0b data=%08h err=%0b strobe=%0b",
               i, rd, wr, a, rd_valid, rd_data, err, out_strobe);
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset mid-read: outputs clear with no clock edge
    drive(1, 0, 32'h10, 32'd0, 10'h155, 1, 1, 0);
    check_model("pre_reset");
    @(negedge clk);
    drive(1, 0, 32'h4000, 32'd0, 10'h155, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    $display("async reset asserted -> valid=%0b data=%08h err=%0b out=%08h", rd_valid, rd_data, err, outport);
    check("areset.rd_valid", {31'd0, rd_valid}, 32'd0);
    check("areset.rd_data", rd_data, 32'd0);
    check("areset.outport", outport, 32'd0);
    check("areset.out_strobe", {31'd0, out_strobe}, 32'd0);
    check("areset.err", {31'd0, err}, 32'd0);
    // Request in flight across reset produces no response
    @(negedge clk);
    MemRead = 1'b1; addr = 32'h10;
    @(posedge clk);
    #1;
    check("areset_inflight.rd_valid", {31'd0, rd_valid}, 32'd0);
    @(negedge clk);
    MemRead = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_reset_idle");
    drive(1, 0, 32'hFFF8, 32'd0, 10'h155, 0, 0, 0);
    $display("post-reset read FFF8 -> valid=%0b data=%08h", rd_valid, rd_data);
    check("post_reset.inport0", rd_data, 32'd0);
    check_model("post_reset_rd");
    drive(1, 0, 32'h10, 32'd0, 10'h155, 0, 0, 0);
    check_model("post_reset_ram");
    idle();
    check_model("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
